timer_cmp: RTL and testbench
============================

// Module: timer_cmp
// PURPOSE
//  Consumer of the 64-bit free-running count produced by the timer counter.
//  Holds a memory-mapped 64-bit compare value and fires a level interrupt to
//  the core when cnt >= cmp. Supports one-shot and periodic (auto-reload) modes.
//  Registers share the counter's addr/wr_en/wdata store bus and expose a read mux.
// PARAMETERS
//  BASE_ADDR  32'h2000000C            first register; block sits above the counter's TDR_1
//  RESET_CMP  64'hFFFF_FFFF_FFFF_FFFF compare reset value (never matches after reset)
// PORTS
//  clk    in   1   single clock; all state updates on its rising edge
//  rst    in   1   asynchronous, active-high reset
//  cnt    in   64  current counter value from the timer counter
//  addr   in   32  store/load address from the core datapath
//  wr_en  in   1   store strobe, qualified by addr
//  wdata  in   32  store data
//  rdata  out  32  combinational read data for addr; 0 when unmapped
//  irq    out  1   timer interrupt, level: pending & IE
//  hit    out  1   1-cycle pulse, registered, on each compare event
// BEHAVIOUR
//  Registers (offset from BASE_ADDR):
//   +0x00 CMP_LO  W: loads shadow_lo only.  R: committed cmp[31:0]
//   +0x04 CMP_HI  W: cmp <= {wdata, shadow_lo} atomically.  R: cmp[63:32]
//   +0x08 PERIOD  R/W 32-bit reload increment, zero-extended to 64 bits
//   +0x0C CTRL    bit0 EN, bit1 PERIODIC, bit2 IE. EN reads 1 iff state != IDLE
//   +0x10 STATUS  bit0 PENDING, write-1-to-clear. Writing 0 has no effect
//  Reset: cmp=RESET_CMP, shadow_lo=0, period=0, PERIODIC=IE=0, PENDING=0,
//   state=IDLE, irq=0, hit=0.
//  FSM (state in timer_pkg):
//   IDLE   -> ARMED   on CTRL write with EN=1
//   ARMED  -> IDLE    on CTRL write with EN=0 (highest priority)
//   ARMED  -> IDLE    on match, when PERIODIC=0 or period==0
//   ARMED  -> RELOAD  on match, when PERIODIC=1 and period!=0
//   RELOAD -> ARMED   next cycle; cmp <= cmp + period (mod 2^64)
//   RELOAD -> IDLE    on CTRL write with EN=0; the reload is dropped
//  match = (state==ARMED) && (cnt >= cmp), 64-bit unsigned, combinational.
//  Latency: on the edge that samples match=1, PENDING<=1 and hit<=1.
//   irq follows PENDING and IE combinationally.
//   Net: cnt first reaches cmp in cycle N -> irq high in cycle N+1.
//  RELOAD ignores cnt, so at most one hit per two cycles.
//  Simultaneous events:
//   - Match and STATUS W1C in the same cycle: set wins, PENDING stays 1.
//   - CMP_HI write and match in the same cycle: the write wins. The match is
//     suppressed, and the state is unchanged.
//   - CMP_HI write during RELOAD: the write wins. The reload add is discarded,
//     and the FSM still returns to ARMED.
//   - CTRL write with EN=1 while ARMED or RELOAD: state unchanged. PERIODIC and
//     IE are updated.
//  Wrap: cmp+period overflow wraps silently. Because cnt >= wrapped cmp, the
//   next cycle in ARMED hits immediately; this is defined behaviour.
//  Clearing IE drops irq without clearing PENDING.
//  rst asserted mid-operation: everything returns to reset values
//   asynchronously, with no partial reload.
//  Only word-aligned exact address matches decode; other addresses write
//   nothing and read 0.
// STRUCTURE
//  timer_pkg:
//   - typedef enum logic[1:0] {IDLE, ARMED, RELOAD} tcmp_state_e
//   - offset localparams OFS_CMP_LO..OFS_STATUS
//   - CTRL bit indices CTRL_EN/CTRL_PER/CTRL_IE
//   - counter TDR address constants, shared with the counter
//  No sub-module. Decode, registers, FSM, 64-bit comparator and 64-bit adder
//   all live inline.
// TESTING
//  1 One-shot: write cmp=100, CTRL=0b101. Drive cnt 98,99,100.
//    -> hit pulse and irq=1 in the cycle after cnt=100; FSM goes IDLE; CTRL
//       reads 0b100.
//  2 Periodic: cmp=10, PERIOD=5, CTRL=0b111. Count from 0.
//    -> hits at cnt=10,15,20, each one cycle late. cmp reads 25 after the
//       third hit.
//  3 Atomic update: CMP_LO=0 with cnt=0x1_0000_0005.
//    -> no hit until the CMP_HI write of 1, which commits 0x1_0000_0000.
//    -> with ARMED, the hit occurs on the cycle after the commit cycle.
//  4 Race: hold the STATUS W1C write in the same cycle as a match.
//    -> PENDING=1 and irq stays high.
//    -> a W1C one cycle later clears it; irq=0 the following cycle.
//  5 Edge cases: PERIODIC=1 with PERIOD=0 -> a single hit, then IDLE.
//    cmp=0xFFFF_FFFF_FFFF_FFFE with PERIOD=4 -> reload to 2 -> immediate
//    re-hit.
//  6 Reset mid-RELOAD: pulse rst -> cmp=all-ones, irq=0 and IDLE immediately,
//    with no clock edge required.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer compare block: FSM states, register
// offsets, CTRL bit positions and the counter's data register addresses.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RELOAD = 2'd2
  } tcmp_state_e;

  localparam logic [31:0] OFS_CMP_LO = 32'h00;
  localparam logic [31:0] OFS_CMP_HI = 32'h04;
  localparam logic [31:0] OFS_PERIOD = 32'h08;
  localparam logic [31:0] OFS_CTRL   = 32'h0C;
  localparam logic [31:0] OFS_STATUS = 32'h10;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_PER = 1;
  localparam int CTRL_IE  = 2;

  // The counter's data registers; the compare block is mapped just above TDR_1.
  localparam logic [31:0] TDR_0_ADDR     = 32'h2000_0004;
  localparam logic [31:0] TDR_1_ADDR     = 32'h2000_0008;
  localparam logic [31:0] TCMP_BASE_ADDR = TDR_1_ADDR + 32'h4;

endpackage

// File: rtl/timer_cmp.sv
// 64-bit compare unit on the timer counter: raises a level interrupt when
// cnt >= cmp, with one-shot or auto-reload (periodic) operation.
module timer_cmp
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2000_000C,
  parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] cnt,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        hit
);

  tcmp_state_e state_q, state_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] period_q, period_d;
  logic        per_q, per_d;
  logic        ie_q, ie_d;
  logic        pending_q, pending_d;
  logic        hit_q;

  logic selLo, selHi, selPeriod, selCtrl, selStatus;
  logic writeLo, writeHi, writePeriod, writeCtrl, writeStatus;
  logic stopReq, match, hitEvent;

  assign selLo     = (addr == BASE_ADDR + OFS_CMP_LO);
  assign selHi     = (addr == BASE_ADDR + OFS_CMP_HI);
  assign selPeriod = (addr == BASE_ADDR + OFS_PERIOD);
  assign selCtrl   = (addr == BASE_ADDR + OFS_CTRL);
  assign selStatus = (addr == BASE_ADDR + OFS_STATUS);

  assign writeLo     = wr_en & selLo;
  assign writeHi     = wr_en & selHi;
  assign writePeriod = wr_en & selPeriod;
  assign writeCtrl   = wr_en & selCtrl;
  assign writeStatus = wr_en & selStatus;

  assign stopReq  = writeCtrl & ~wdata[CTRL_EN];
  assign match    = (state_q == ARMED) && (cnt >= cmp_q);
  // A CMP_HI commit in the same cycle overrides the compare event entirely.
  assign hitEvent = match & ~writeHi;

  always_comb begin
    state_d = state_q;
    cmp_d   = cmp_q;
    unique case (state_q)
      IDLE: begin
        if (writeCtrl && wdata[CTRL_EN]) state_d = ARMED;
      end
      ARMED: begin
        if (stopReq) state_d = IDLE;
        else if (hitEvent) state_d = (per_q && period_q != 32'd0) ? RELOAD : IDLE;
      end
      RELOAD: begin
        if (stopReq) begin
          state_d = IDLE;
        end else begin
          state_d = ARMED;
          cmp_d   = cmp_q + {32'd0, period_q};
        end
      end
      default: state_d = IDLE;
    endcase
    if (writeHi) cmp_d = {wdata, shadow_q};
  end

  always_comb begin
    shadow_d  = writeLo ? wdata : shadow_q;
    period_d  = writePeriod ? wdata : period_q;
    per_d     = writeCtrl ? wdata[CTRL_PER] : per_q;
    ie_d      = writeCtrl ? wdata[CTRL_IE] : ie_q;
    pending_d = pending_q;
    if (writeStatus && wdata[0]) pending_d = 1'b0;
    if (hitEvent) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cmp_q     <= RESET_CMP;
      shadow_q  <= '0;
      period_q  <= '0;
      per_q     <= 1'b0;
      ie_q      <= 1'b0;
      pending_q <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmp_q     <= cmp_d;
      shadow_q  <= shadow_d;
      period_q  <= period_d;
      per_q     <= per_d;
      ie_q      <= ie_d;
      pending_q <= pending_d;
      hit_q     <= hitEvent;
    end
  end

  always_comb begin
    rdata = '0;
    if (selLo)          rdata = cmp_q[31:0];
    else if (selHi)     rdata = cmp_q[63:32];
    else if (selPeriod) rdata = period_q;
    else if (selCtrl)   rdata = {29'd0, ie_q, per_q, state_q != IDLE};
    else if (selStatus) rdata = {31'd0, pending_q};
  end

  assign irq = pending_q & ie_q;
  assign hit = hit_q;

endmodule

// File: tb/tb_timer_cmp.sv
// Self-checking bench for timer_cmp: directed scenarios plus randomized bus
// traffic, all compared against a behavioural model of the register map.
module tb_timer_cmp;
  import timer_pkg::*;

  localparam logic [31:0] BASE     = 32'h2000_000C;
  localparam logic [31:0] A_LO     = BASE + OFS_CMP_LO;
  localparam logic [31:0] A_HI     = BASE + OFS_CMP_HI;
  localparam logic [31:0] A_PERIOD = BASE + OFS_PERIOD;
  localparam logic [31:0] A_CTRL   = BASE + OFS_CTRL;
  localparam logic [31:0] A_STATUS = BASE + OFS_STATUS;
  localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cnt;
  logic [31:0] addr, wdata, rdata;
  logic        wr_en, irq, hit;

  int compared = 0;
  int mismatched = 0;

  logic [63:0] mCmp;
  logic [31:0] mShadow, mPeriod;
  bit          mPer, mIe, mPending, mHit, mRunning, mReloading;

  logic [31:0] lastRdata;
  logic        lastHit, lastIrq;
  int          hitCount, hitSum;

  timer_cmp #(.BASE_ADDR(BASE), .RESET_CMP(ONES)) dut (
    .clk(clk), .rst(rst), .cnt(cnt), .addr(addr), .wr_en(wr_en),
    .wdata(wdata), .rdata(rdata), .irq(irq), .hit(hit)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mCmp = ONES; mShadow = '0; mPeriod = '0;
    mPer = 0; mIe = 0; mPending = 0; mHit = 0; mRunning = 0; mReloading = 0;
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (a == A_LO)     return mCmp[31:0];
    if (a == A_HI)     return mCmp[63:32];
    if (a == A_PERIOD) return mPeriod;
    if (a == A_CTRL)   return {29'd0, mIe, mPer, mRunning};
    if (a == A_STATUS) return {31'd0, mPending};
    return 32'd0;
  endfunction

  // The timer either runs (waiting for cnt to reach cmp, or adding the period
  // for one cycle after a periodic hit) or stops; bus writes apply on the edge.
  task automatic modelStep(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [63:0] c);
    bit wHi, wCtrl, fire, nextRunning, nextReload;
    logic [63:0] nextCmp;
    wHi   = w && a == A_HI;
    wCtrl = w && a == A_CTRL;
    fire  = mRunning && !mReloading && c >= mCmp && !wHi;
    nextCmp = mCmp;
    nextRunning = mRunning;
    nextReload = 0;
    if (mReloading) nextCmp = mCmp + {32'd0, mPeriod};
    if (fire) begin
      if (mPer && mPeriod != 0) nextReload = 1;
      else nextRunning = 0;
    end
    if (wCtrl) begin
      if (d[0]) begin
        if (!mRunning) nextRunning = 1;
      end else begin
        nextRunning = 0;
        nextReload = 0;
        nextCmp = mCmp;
      end
    end
    if (wHi) nextCmp = {d, mShadow};
    if (w && a == A_STATUS && d[0]) mPending = 0;
    if (fire) mPending = 1;
    mHit = fire;
    if (w && a == A_LO) mShadow = d;
    if (w && a == A_PERIOD) mPeriod = d;
    if (wCtrl) begin mPer = d[1]; mIe = d[2]; end
    mCmp = nextCmp;
    mRunning = nextRunning;
    mReloading = nextReload && nextRunning;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [63:0] c);
    @(negedge clk);
    addr = a; wr_en = w; wdata = d; cnt = c;
    #1;
    lastRdata = rdata;
    checkOutput("rdata", 64'(rdata), 64'(modelRead(a)));
    checkOutput("irq", 64'(irq), 64'(mPending & mIe));
    @(posedge clk);
    modelStep(a, w, d, c);
    #1;
    lastHit = hit;
    lastIrq = irq;
    checkOutput("hit", 64'(hit), 64'(mHit));
    checkOutput("irqPost", 64'(irq), 64'(mPending & mIe));
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [63:0] c);
    applyStimulus(a, 1'b1, d, c);
  endtask

  task automatic idleCycle(input logic [63:0] c);
    applyStimulus(A_CTRL, 1'b0, 32'd0, c);
  endtask

  initial begin
    logic [63:0] rc;
    logic [31:0] ra, rd;
    rst = 1'b1; cnt = '0; addr = A_LO; wr_en = 1'b0; wdata = '0;
    modelReset();
    #12;
    checkOutput("reset cmpLo", 64'(rdata), 64'hFFFF_FFFF);
    checkOutput("reset irq", 64'(irq), 64'd0);
    checkOutput("reset hit", 64'(hit), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // One-shot
    busWrite(A_LO, 32'd100, 64'd0);
    busWrite(A_HI, 32'd0, 64'd0);
    busWrite(A_CTRL, 32'b101, 64'd0);
    idleCycle(64'd98);
    idleCycle(64'd99);
    checkOutput("t1 early hit", 64'(lastHit), 64'd0);
    idleCycle(64'd100);
    checkOutput("t1 hit", 64'(lastHit), 64'd1);
    checkOutput("t1 irq", 64'(lastIrq), 64'd1);
    idleCycle(64'd101);
    checkOutput("t1 ctrl", 64'(lastRdata), 64'd4);
    checkOutput("t1 hit pulse", 64'(lastHit), 64'd0);
    busWrite(A_STATUS, 32'd1, 64'd101);

    // Periodic
    busWrite(A_LO, 32'd10, 64'd0);
    busWrite(A_HI, 32'd0, 64'd0);
    busWrite(A_PERIOD, 32'd5, 64'd0);
    busWrite(A_CTRL, 32'b111, 64'd0);
    hitCount = 0; hitSum = 0;
    for (int c = 0; c <= 22; c++) begin
      idleCycle(64'(c));
      if (lastHit) begin hitCount++; hitSum += c; end
    end
    applyStimulus(A_LO, 1'b0, 32'd0, 64'd23);
    checkOutput("t2 cmp", 64'(lastRdata), 64'd25);
    checkOutput("t2 hits", 64'(hitCount), 64'd3);
    checkOutput("t2 hitSum", 64'(hitSum), 64'd45);
    busWrite(A_CTRL, 32'd0, 64'd23);
    busWrite(A_STATUS, 32'd1, 64'd23);

    // Atomic 64-bit update
    rc = 64'h1_0000_0005;
    busWrite(A_LO, 32'd0, rc);
    busWrite(A_HI, 32'd2, rc);
    busWrite(A_CTRL, 32'b001, rc);
    busWrite(A_LO, 32'd0, rc);
    idleCycle(rc);
    checkOutput("t3 no hit", 64'(lastHit), 64'd0);
    busWrite(A_HI, 32'd1, rc);
    checkOutput("t3 commit", 64'(lastHit), 64'd0);
    idleCycle(rc);
    checkOutput("t3 hit", 64'(lastHit), 64'd1);
    busWrite(A_STATUS, 32'd1, rc);

    // W1C racing a match
    busWrite(A_LO, 32'd60, 64'd50);
    busWrite(A_HI, 32'd0, 64'd50);
    busWrite(A_CTRL, 32'b101, 64'd50);
    idleCycle(64'd55);
    busWrite(A_STATUS, 32'd1, 64'd60);
    checkOutput("t4 race irq", 64'(lastIrq), 64'd1);
    busWrite(A_STATUS, 32'd1, 64'd61);
    checkOutput("t4 cleared irq", 64'(lastIrq), 64'd0);

    // Periodic with zero period fires once
    busWrite(A_CTRL, 32'd0, 64'd0);
    busWrite(A_PERIOD, 32'd0, 64'd0);
    busWrite(A_LO, 32'd200, 64'd0);
    busWrite(A_HI, 32'd0, 64'd0);
    busWrite(A_CTRL, 32'b011, 64'd0);
    hitCount = 0;
    for (int i = 0; i < 6; i++) begin
      idleCycle(64'd200);
      if (lastHit) hitCount++;
    end
    checkOutput("t5 single hit", 64'(hitCount), 64'd1);
    checkOutput("t5 ctrl", 64'(lastRdata), 64'd2);
    busWrite(A_STATUS, 32'd1, 64'd200);

    // Reload wrapping past 2^64
    busWrite(A_PERIOD, 32'd4, 64'd0);
    busWrite(A_LO, 32'hFFFF_FFFE, 64'd0);
    busWrite(A_HI, 32'hFFFF_FFFF, 64'd0);
    busWrite(A_CTRL, 32'b111, ONES);
    idleCycle(ONES);
    checkOutput("t5 wrap hit1", 64'(lastHit), 64'd1);
    idleCycle(ONES);
    checkOutput("t5 wrap reload", 64'(lastHit), 64'd0);
    idleCycle(ONES);
    checkOutput("t5 wrap hit2", 64'(lastHit), 64'd1);
    applyStimulus(A_LO, 1'b0, 32'd0, ONES);
    checkOutput("t5 wrapped cmp", 64'(lastRdata), 64'd2);
    idleCycle(ONES);
    checkOutput("t6 pre hit", 64'(lastHit), 64'd1);

    // Asynchronous reset while reloading
    @(negedge clk);
    wr_en = 1'b0; addr = A_LO;
    #1;
    checkOutput("t6 irq before", 64'(irq), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6 irq", 64'(irq), 64'd0);
    checkOutput("t6 hit", 64'(hit), 64'd0);
    checkOutput("t6 cmpLo", 64'(rdata), 64'hFFFF_FFFF);
    addr = A_HI;
    #1;
    checkOutput("t6 cmpHi", 64'(rdata), 64'hFFFF_FFFF);
    addr = A_CTRL;
    #1;
    checkOutput("t6 ctrl", 64'(rdata), 64'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized bus traffic around a slowly advancing counter
    rc = 64'hFFFF_FF00;
    for (int i = 0; i < 600; i++) begin
      rc = rc + 64'($urandom_range(0, 3));
      case ($urandom_range(0, 11))
        0: busWrite(A_LO, rc[31:0] + 32'($urandom_range(0, 30)), rc);
        1: busWrite(A_HI, rc[63:32] + 32'($urandom_range(0, 1)), rc);
        2: busWrite(A_PERIOD, 32'($urandom_range(0, 6)), rc);
        3, 4: busWrite(A_CTRL, 32'($urandom_range(0, 7)), rc);
        5: busWrite(A_STATUS, $urandom, rc);
        6: begin
          ra = ($urandom_range(0, 1) == 0) ? BASE + 32'h14 : BASE + 32'h1;
          busWrite(ra, $urandom, rc);
        end
        default: begin
          case ($urandom_range(0, 6))
            0: ra = A_LO;
            1: ra = A_HI;
            2: ra = A_PERIOD;
            3: ra = A_CTRL;
            4: ra = A_STATUS;
            5: ra = BASE + 32'h2;
            default: ra = TDR_1_ADDR;
          endcase
          rd = $urandom;
          applyStimulus(ra, 1'b0, rd, rc);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
